// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter for the core's memory-mapped TX port.
//   A store to the TX address pushes one byte into a circular FIFO. A small
//   FSM pops queued bytes and serialises them LSB first on uart_tx. Frames
//   run back to back while data is queued. A status word for the load path
//   lets software poll occupancy, busy, full, empty and a sticky overflow flag.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   wr_en         push request (one byte per cycle)
//   wr_data       byte to push
//   clr_ovf       clears the sticky overflow flag
//   uart_tx       registered serial line (idle high)
//   full          FIFO holds DEPTH entries (registered)
//   empty         FIFO holds 0 entries (registered)
//   busy          transmitter FSM not idle (registered)
//   count         current occupancy (registered)
//   status_value  {16'd0, count[7:0], 4'd0, ovf, busy, full, empty}
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_ovf,
  output logic                     uart_tx,
  output logic                     full,
  output logic                     empty,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              status_value
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ZERO  = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
  localparam logic [PW-1:0] PTR_ZERO   = PW'(0);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Serial line level for a given FSM state; the data bit is the shift LSB.
  function automatic logic line_level(input state_t st, input logic lsb);
    logic lvl;
    case (st)
      ST_IDLE:  lvl = 1'b1;
      ST_START: lvl = 1'b0;
      ST_DATA:  lvl = lsb;
      ST_STOP:  lvl = 1'b1;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;

  // Transmitter state
  state_t        r_state;
  logic [7:0]    r_shreg;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_tx;
  logic          r_busy;

  // Combinational helpers
  logic          w_push;
  logic          w_pop;
  logic          w_overflow;
  logic          w_bit_end;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_rd_data;
  logic [7:0]    w_count8;

  // A push is judged against the registered full flag only, so a pop in the
  // same cycle does not make room for an otherwise-overflowing byte.
  assign w_push     = wr_en & ~r_full;
  assign w_overflow = wr_en & r_full;
  assign w_bit_end  = (r_baud_cnt == BAUD_LAST);
  assign w_rd_data  = r_mem[r_rd_ptr];

  // Pop request: leaving IDLE, or chaining straight from the last STOP cycle
  // into the next START. Based on registered empty, so a byte pushed into an
  // empty FIFO cannot be popped in the same cycle.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = ~r_empty;
      ST_STOP: w_pop = ~r_empty & w_bit_end;
      default: w_pop = 1'b0;
    endcase
  end

  // Next occupancy: +1 push only, -1 pop only, otherwise unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + COUNT_ONE;
      2'b01:   w_count_nxt = r_count - COUNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Byte storage; contents need no reset because pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= COUNT_ZERO;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == COUNT_FULL);
      r_empty <= (w_count_nxt == COUNT_ZERO);
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_overflow) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Transmitter FSM with registered busy and line outputs. The line register
  // follows the state one cycle later, giving the two-cycle push-to-start
  // latency while keeping every bit exactly CLKS_PER_BIT cycles long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= 8'h00;
      r_baud_cnt <= BAUD_ZERO;
      r_bit_idx  <= 3'd0;
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= line_level(r_state, r_shreg[0]);
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= BAUD_ZERO;
          r_bit_idx  <= 3'd0;
          if (w_pop) begin
            r_state <= ST_START;
            r_shreg <= w_rd_data;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state    <= ST_DATA;
            r_baud_cnt <= BAUD_ZERO;
            r_bit_idx  <= 3'd0;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= BAUD_ZERO;
            r_shreg    <= {1'b0, r_shreg[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state   <= ST_STOP;
              r_bit_idx <= 3'd0;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= BAUD_ZERO;
            if (w_pop) begin
              // Back-to-back frame: no idle cycle after the stop bit.
              r_state <= ST_START;
              r_shreg <= w_rd_data;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_baud_cnt <= BAUD_ZERO;
          r_bit_idx  <= 3'd0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign w_count8     = 8'(r_count);
  assign uart_tx      = r_tx;
  assign full         = r_full;
  assign empty        = r_empty;
  assign busy         = r_busy;
  assign count        = r_count;
  assign status_value = {16'h0000, w_count8, 4'h0, r_ovf, r_busy, r_full, r_empty};

endmodule
